axil_rr_interconnect: RTL



---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_rr_arbiter.sv | 77 +++++++
 rtl/axil_rr_interconnect.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI4-Lite response codes and FSM state encodings for
//               the round-robin interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_arbiter
// Description : Round-robin arbiter with grant lock. While unlocked the grant
//               is the first requester at or above the pointer (wrapping);
//               the first cycle with any request locks that winner until
//               'advance', which moves the pointer to winner+1 mod N.
// Ports       : ACLK/ARESET  clock, synchronous active-high reset
//               req          request vector
//               advance      end of locked transaction
//               grant_idx    current (or locked) winner
//               grant_valid  a winner exists (locked or any request)
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] win;
  logic          found;

  // Scan N positions starting at the pointer, wrapping past N-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign grant_idx   = lock_q ? lock_idx_q : win;
  assign grant_valid = lock_q | found;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (lock_q && advance) begin
      lock_d = 1'b0;
      ptr_d  = (lock_idx_q == IW'(N - 1)) ? '0 : lock_idx_q + 1'b1;
    end else if (!lock_q && found) begin
      lock_d     = 1'b1;
      lock_idx_d = win;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule : axil_rr_arbiter
`default_nettype wire

// File: rtl/axil_rr_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_interconnect
// Description : NM-master to NS-slave AXI4-Lite shared bus. Independent
//               read and write paths, each with a round-robin arbiter whose
//               grant is held for the whole transaction. Unmapped addresses
//               are answered internally with DECERR.
// Ports       : ACLK/ARESET  clock, synchronous active-high reset
//               M_*          NM flattened master-side AXI4-Lite channels
//               S_*          NS flattened slave-side AXI4-Lite channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_interconnect
  import axil_pkg::*;
#(
  parameter int                           NM         = 2,
  parameter int                           NS         = 3,
  parameter int                           AXI_AWIDTH = 32,
  parameter int                           AXI_DWIDTH = 32,
  parameter logic [NS*AXI_AWIDTH-1:0]     S_BASE     = {32'hF0000000, 32'h40000000, 32'h00000000},
  parameter logic [NS*AXI_AWIDTH-1:0]     S_END      = {32'hF0000007, 32'h5FFFFFFF, 32'h3FFFFFFF},
  parameter logic [NS-1:0]                S_EN       = 3'b111
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NM*AXI_AWIDTH-1:0]     M_AWADDR,
  input  logic [NM*3-1:0]              M_AWPROT,
  input  logic [NM-1:0]                M_AWVALID,
  output logic [NM-1:0]                M_AWREADY,
  input  logic [NM*AXI_DWIDTH-1:0]     M_WDATA,
  input  logic [NM*AXI_DWIDTH/8-1:0]   M_WSTRB,
  input  logic [NM-1:0]                M_WVALID,
  output logic [NM-1:0]                M_WREADY,
  output logic [NM*2-1:0]              M_BRESP,
  output logic [NM-1:0]                M_BVALID,
  input  logic [NM-1:0]                M_BREADY,
  input  logic [NM*AXI_AWIDTH-1:0]     M_ARADDR,
  input  logic [NM*3-1:0]              M_ARPROT,
  input  logic [NM-1:0]                M_ARVALID,
  output logic [NM-1:0]                M_ARREADY,
  output logic [NM*AXI_DWIDTH-1:0]     M_RDATA,
  output logic [NM*2-1:0]              M_RRESP,
  output logic [NM-1:0]                M_RVALID,
  input  logic [NM-1:0]                M_RREADY,
  output logic [NS*AXI_AWIDTH-1:0]     S_AWADDR,
  output logic [NS*3-1:0]              S_AWPROT,
  output logic [NS-1:0]                S_AWVALID,
  input  logic [NS-1:0]                S_AWREADY,
  output logic [NS*AXI_DWIDTH-1:0]     S_WDATA,
  output logic [NS*AXI_DWIDTH/8-1:0]   S_WSTRB,
  output logic [NS-1:0]                S_WVALID,
  input  logic [NS-1:0]                S_WREADY,
  input  logic [NS*2-1:0]              S_BRESP,
  input  logic [NS-1:0]                S_BVALID,
  output logic [NS-1:0]                S_BREADY,
  output logic [NS*AXI_AWIDTH-1:0]     S_ARADDR,
  output logic [NS*3-1:0]              S_ARPROT,
  output logic [NS-1:0]                S_ARVALID,
  input  logic [NS-1:0]                S_ARREADY,
  input  logic [NS*AXI_DWIDTH-1:0]     S_RDATA,
  input  logic [NS*2-1:0]              S_RRESP,
  input  logic [NS-1:0]                S_RVALID,
  output logic [NS-1:0]                S_RREADY
);

  localparam int AW  = AXI_AWIDTH;
  localparam int DW  = AXI_DWIDTH;
  localparam int SB  = AXI_DWIDTH / 8;
  localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;

  // Returns {miss, slave index}; the ascending scan makes the lowest index
  // win when ranges overlap.
  function automatic logic [SIW:0] decode(input logic [AW-1:0] addr);
    logic           hit;
    logic [SIW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && S_EN[i] && addr >= S_BASE[i*AW +: AW] && addr <= S_END[i*AW +: AW]) begin
        hit = 1'b1;
        idx = SIW'(i);
      end
    end
    return {~hit, idx};
  endfunction

  // ---------------------------------------------------------------- write
  wstate_e        w_state_q, w_state_d;
  logic           aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic           w_err_q, w_err_d;
  logic [SIW-1:0] w_slv_q, w_slv_d;
  logic [MIW-1:0] w_gnt;
  logic           w_gnt_valid, w_adv;
  logic           aw_rdy, wd_rdy, aw_hs, wd_hs, b_vld;
  int             w_gi, w_si;

  axil_rr_arbiter #(.N(NM)) u_warb (
    .ACLK(ACLK), .ARESET(ARESET), .req(M_AWVALID), .advance(w_adv),
    .grant_idx(w_gnt), .grant_valid(w_gnt_valid)
  );

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_err_d   = w_err_q;
    w_slv_d   = w_slv_q;
    w_adv     = 1'b0;
    aw_rdy    = 1'b0;
    wd_rdy    = 1'b0;
    aw_hs     = 1'b0;
    wd_hs     = 1'b0;
    b_vld     = 1'b0;
    w_gi      = int'(w_gnt);
    w_si      = int'(w_slv_q);
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BRESP   = '0;
    M_BVALID  = '0;
    S_AWADDR  = '0;
    S_AWPROT  = '0;
    S_AWVALID = '0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WVALID  = '0;
    S_BREADY  = '0;
    // Outputs are forced quiet while ARESET is high, whatever state holds.
    if (!ARESET) begin
      case (w_state_q)
        W_IDLE: begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (w_gnt_valid) begin
            {w_err_d, w_slv_d} = decode(M_AWADDR[w_gi*AW +: AW]);
            w_state_d = W_ADDR;
          end
        end
        W_ADDR: begin
          aw_rdy = w_err_q ? 1'b1 : S_AWREADY[w_si];
          wd_rdy = w_err_q ? 1'b1 : S_WREADY[w_si];
          if (!aw_done_q) begin
            M_AWREADY[w_gi] = aw_rdy;
            aw_hs           = M_AWVALID[w_gi] & aw_rdy;
            if (!w_err_q) begin
              S_AWVALID[w_si]            = M_AWVALID[w_gi];
              S_AWADDR[w_si*AW +: AW]    = M_AWADDR[w_gi*AW +: AW];
              S_AWPROT[w_si*3 +: 3]      = M_AWPROT[w_gi*3 +: 3];
            end
          end
          if (!w_done_q) begin
            M_WREADY[w_gi] = wd_rdy;
            wd_hs          = M_WVALID[w_gi] & wd_rdy;
            if (!w_err_q) begin
              S_WVALID[w_si]             = M_WVALID[w_gi];
              S_WDATA[w_si*DW +: DW]     = M_WDATA[w_gi*DW +: DW];
              S_WSTRB[w_si*SB +: SB]     = M_WSTRB[w_gi*SB +: SB];
            end
          end
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | wd_hs;
          if (aw_done_d && w_done_d) w_state_d = W_RESP;
        end
        W_RESP: begin
          if (w_err_q) begin
            b_vld                  = 1'b1;
            M_BRESP[w_gi*2 +: 2]   = RESP_DECERR;
          end else begin
            b_vld                  = S_BVALID[w_si];
            M_BRESP[w_gi*2 +: 2]   = S_BRESP[w_si*2 +: 2];
            S_BREADY[w_si]         = M_BREADY[w_gi];
          end
          M_BVALID[w_gi] = b_vld;
          if (b_vld && M_BREADY[w_gi]) begin
            w_adv     = 1'b1;
            w_state_d = W_IDLE;
          end
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      w_err_q   <= 1'b0;
      w_slv_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      w_err_q   <= w_err_d;
      w_slv_q   <= w_slv_d;
    end
  end

  // ----------------------------------------------------------------- read
  rstate_e        r_state_q, r_state_d;
  logic           r_err_q, r_err_d;
  logic [SIW-1:0] r_slv_q, r_slv_d;
  logic [MIW-1:0] r_gnt;
  logic           r_gnt_valid, r_adv;
  logic           ar_rdy, r_vld;
  int             r_gi, r_si;

  axil_rr_arbiter #(.N(NM)) u_rarb (
    .ACLK(ACLK), .ARESET(ARESET), .req(M_ARVALID), .advance(r_adv),
    .grant_idx(r_gnt), .grant_valid(r_gnt_valid)
  );

  always_comb begin
    r_state_d = r_state_q;
    r_err_d   = r_err_q;
    r_slv_d   = r_slv_q;
    r_adv     = 1'b0;
    ar_rdy    = 1'b0;
    r_vld     = 1'b0;
    r_gi      = int'(r_gnt);
    r_si      = int'(r_slv_q);
    M_ARREADY = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    M_RVALID  = '0;
    S_ARADDR  = '0;
    S_ARPROT  = '0;
    S_ARVALID = '0;
    S_RREADY  = '0;
    if (!ARESET) begin
      case (r_state_q)
        R_IDLE: begin
          if (r_gnt_valid) begin
            {r_err_d, r_slv_d} = decode(M_ARADDR[r_gi*AW +: AW]);
            r_state_d = R_ADDR;
          end
        end
        R_ADDR: begin
          ar_rdy          = r_err_q ? 1'b1 : S_ARREADY[r_si];
          M_ARREADY[r_gi] = ar_rdy;
          if (!r_err_q) begin
            S_ARVALID[r_si]          = M_ARVALID[r_gi];
            S_ARADDR[r_si*AW +: AW]  = M_ARADDR[r_gi*AW +: AW];
            S_ARPROT[r_si*3 +: 3]    = M_ARPROT[r_gi*3 +: 3];
          end
          if (M_ARVALID[r_gi] && ar_rdy) r_state_d = R_DATA;
        end
        R_DATA: begin
          if (r_err_q) begin
            r_vld                 = 1'b1;
            M_RRESP[r_gi*2 +: 2]  = RESP_DECERR;
          end else begin
            r_vld                  = S_RVALID[r_si];
            M_RDATA[r_gi*DW +: DW] = S_RDATA[r_si*DW +: DW];
            M_RRESP[r_gi*2 +: 2]   = S_RRESP[r_si*2 +: 2];
            S_RREADY[r_si]         = M_RREADY[r_gi];
          end
          M_RVALID[r_gi] = r_vld;
          if (r_vld && M_RREADY[r_gi]) begin
            r_adv     = 1'b1;
            r_state_d = R_IDLE;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      r_err_q   <= 1'b0;
      r_slv_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_err_q   <= r_err_d;
      r_slv_q   <= r_slv_d;
    end
  end

endmodule : axil_rr_interconnect
`default_nettype wire
